// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the 5-stage MIPS pipeline.
//
// Holds the program counter and the IF/ID pipeline register. It picks the next PC from the
// sequential, branch, jump, jr, interrupt-vector and exception-vector sources. It also runs a
// small FSM that decides when a pending timer interrupt may enter.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   irq               level interrupt request from the timer
//   stall             load-use hazard from ID; freezes PC and IF/ID
//   exc               undefined instruction decoded in ID this cycle
//   br_taken          branch resolved taken in EX, with br_target
//   jmp               j/jal decoded in ID (target from IF/ID)
//   jr                jr/jalr decoded in ID, with jr_addr
//   rom_data          combinational instruction ROM output for rom_addr
//   rom_addr          current PC
//   if_id_instr       registered instruction (0 when bubble)
//   if_id_pc4         registered PC+4
//   if_id_valid       0 marks a bubble
//   id_flush          squash the instruction currently in ID
//   irq_ack           one-cycle pulse, the cycle after the interrupt is taken
//   epc_out           return address for $26, valid with exc, at irq take and with irq_ack
//   kernel            PC[31]
module fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        stall,
    input  logic        exc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] rom_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        id_flush,
    output logic        irq_ack,
    output logic [31:0] epc_out,
    output logic        kernel
);

    typedef enum logic [1:0] {StRun, StPend, StKern} irq_state_e;

    irq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        ack_q;
    logic [31:0] epc_q;

    logic [31:0] pc4;
    logic [31:0] jmp_target;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        cti;
    logic        irq_take;
    logic        bubble;

    // Datapath helpers and the interrupt-entry qualifier.
    always_comb begin
        // Kernel bit is sticky across the increment; only the low 31 bits count.
        pc4        = {pc_q[31], pc_q[30:0] + 31'd4};
        jmp_target = {pc4_q[31:28], instr_q[25:0], 2'b00};
        op         = instr_q[31:26];
        funct      = instr_q[5:0];
        cti        = 1'b0;
        if (valid_q) begin
            if (op inside {6'b000001, 6'b000010, 6'b000011, 6'b000100,
                           6'b000101, 6'b000110, 6'b000111}) begin
                cti = 1'b1;
            end else if (op == 6'b000000 && funct inside {6'b001000, 6'b001001}) begin
                cti = 1'b1;
            end
        end
        // Only enter on a quiet cycle so the saved PC is never a speculative fetch.
        irq_take = (state_q == StPend) && !pc_q[31] && !br_taken && !exc && !jr && !jmp
                   && !stall && !cti;
    end

    // Next-PC arbitration and IF/ID update.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        bubble  = 1'b0;

        if (br_taken) begin
            pc_d   = br_target;
            bubble = 1'b1;
        end else if (exc) begin
            pc_d   = EXC_VEC;
            bubble = 1'b1;
        end else if (irq_take) begin
            pc_d   = IRQ_VEC;
            bubble = 1'b1;
        end else if (jr) begin
            pc_d   = jr_addr;
            bubble = 1'b1;
        end else if (jmp) begin
            pc_d   = jmp_target;
            bubble = 1'b1;
        end else if (!stall) begin
            pc_d    = pc4;
            instr_d = rom_data;
            pc4_d   = pc4;
            valid_d = 1'b1;
        end

        if (bubble) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end
    end

    // Interrupt FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:  if (irq && !pc_q[31]) state_d = StPend;
            StPend: begin
                if (irq_take) begin
                    state_d = StKern;
                end else if (!irq) begin
                    state_d = StRun;
                end
            end
            StKern: if (!pc_q[31]) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= RESET_VEC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            ack_q   <= irq_take;
            if (irq_take) begin
                epc_q <= pc_q;
            end
        end
    end

    assign rom_addr    = pc_q;
    assign kernel      = pc_q[31];
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign irq_ack     = ack_q;
    assign id_flush    = br_taken | exc;
    // Live PC during the take cycle, then held for the irq_ack cycle.
    assign epc_out     = exc ? pc4_q : (irq_take ? pc_q : epc_q);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal expectations,
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] ADDU      = 32'h0085_1021;
    localparam logic [31:0] BEQ       = 32'h1000_0003;

    logic        clk = 1'b0;
    logic        reset, irq, stall, exc, br_taken, jmp, jr;
    logic [31:0] br_target, jr_addr, rom_data, rom_addr, if_id_instr, if_id_pc4, epc_out;
    logic        if_id_valid, id_flush, irq_ack, kernel;

    logic [31:0] rom [256];

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[9:2]];

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .stall       (stall),
        .exc         (exc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp         (jmp),
        .jr          (jr),
        .jr_addr     (jr_addr),
        .rom_data    (rom_data),
        .rom_addr    (rom_addr),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .id_flush    (id_flush),
        .irq_ack     (irq_ack),
        .epc_out     (epc_out),
        .kernel      (kernel)
    );

    // Behavioural model: architectural PC, IF/ID contents and interrupt phase
    // (0 = idle, 1 = request pending, 2 = inside handler).
    logic [31:0] m_pc, m_instr, m_pc4, m_epc;
    logic        m_valid, m_ack;
    int          m_phase;
    bit          m_known;
    bit          irq_lvl;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_cti();
        logic [5:0] op;
        logic [5:0] fn;
        op = m_instr[31:26];
        fn = m_instr[5:0];
        if (!m_valid) return 1'b0;
        return (op inside {[6'd1:6'd7]}) || (op == 6'd0 && fn inside {6'd8, 6'd9});
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic step(input bit r, input bit i, input bit s, input bit e, input bit b,
                        input logic [31:0] bt, input bit j, input bit jrr,
                        input logic [31:0] ja);
        bit          take;
        logic [31:0] seq, jt, fetched, n_pc, exp_epc;
        bit          bub;
        @(negedge clk);
        reset = r; irq = i; stall = s; exc = e; br_taken = b; br_target = bt;
        jmp = j; jr = jrr; jr_addr = ja;
        #1;
        take = (m_phase == 1) && !m_pc[31] && !b && !e && !jrr && !j && !s && !m_cti();
        if (m_known) begin
            chk("rom_addr", rom_addr, m_pc);
            chk("kernel", {31'd0, kernel}, {31'd0, m_pc[31]});
            chk("if_id_instr", if_id_instr, m_instr);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            if (m_valid) chk("if_id_pc4", if_id_pc4, m_pc4);
            chk("id_flush", {31'd0, id_flush}, {31'd0, b | e});
            chk("irq_ack", {31'd0, irq_ack}, {31'd0, m_ack});
            if (!r && ((e && !b) || take || m_ack)) begin
                exp_epc = e ? m_pc4 : (take ? m_pc : m_epc);
                chk("epc_out", epc_out, exp_epc);
            end
        end
        if (r) begin
            m_pc = RESET_VEC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_phase = 0; m_ack = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            seq     = {m_pc[31], m_pc[30:0] + 31'd4};
            jt      = {m_pc4[31:28], m_instr[25:0], 2'b00};
            fetched = rom[m_pc[9:2]];
            n_pc    = m_pc;
            bub     = 1'b1;
            if (b)         n_pc = bt;
            else if (e)    n_pc = EXC_VEC;
            else if (take) n_pc = IRQ_VEC;
            else if (jrr)  n_pc = ja;
            else if (j)    n_pc = jt;
            else begin
                bub = 1'b0;
                if (!s) begin
                    n_pc = seq; m_instr = fetched; m_pc4 = seq; m_valid = 1'b1;
                end
            end
            if (bub) begin
                m_instr = 0; m_pc4 = 0; m_valid = 1'b0;
            end
            case (m_phase)
                0: if (i && !m_pc[31]) m_phase = 1;
                1: if (take) m_phase = 2; else if (!i) m_phase = 0;
                default: if (!m_pc[31]) m_phase = 0;
            endcase
            if (take) m_epc = m_pc;
            m_ack = take;
            m_pc  = n_pc;
        end
    endtask

    task automatic idle();
        step(0, irq_lvl, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int sel;
        bit r, s, e, b, j, jrr;
        logic [31:0] bt, ja;

        reset = 1'b1; irq = 0; stall = 0; exc = 0; br_taken = 0; br_target = 0;
        jmp = 0; jr = 0; jr_addr = 0;
        m_known = 1'b0; irq_lvl = 1'b0;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_epc = 0; m_valid = 0; m_ack = 0; m_phase = 0;

        for (int k = 0; k < 256; k++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: rom[k] = ADDU;
                1: rom[k] = {6'b000100, 10'($urandom), 16'($urandom)};
                2: rom[k] = {6'b000010, 26'($urandom)};
                3: rom[k] = 32'h03E0_0008;
                4: rom[k] = {6'b100011, 26'($urandom)};
                default: rom[k] = $urandom;
            endcase
        end
        rom[0] = 0; rom[1] = 0; rom[2] = 0; rom[3] = 32'h0800_002F; rom[47] = 0;
        for (int k = 5; k <= 9; k++) rom[k] = ADDU;
        for (int k = 30; k <= 32; k++) rom[k] = ADDU;
        rom[33] = BEQ;
        for (int k = 34; k <= 36; k++) rom[k] = ADDU;
        for (int k = 64; k <= 67; k++) rom[k] = ADDU;

        // Reset, then sequential fetch from the reset vector.
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); chk("lit_pc_a", rom_addr, 32'h8000_0000);
        chk("lit_valid_a", {31'd0, if_id_valid}, 32'd0);
        idle(); chk("lit_pc_b", rom_addr, 32'h8000_0004);
        idle(); chk("lit_pc_c", rom_addr, 32'h8000_0008);
        idle();
        // ID holds j 0x0800002F.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); chk("lit_j_instr", if_id_instr, 32'h0800_002F);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0014);
        chk("lit_j_target", rom_addr, 32'h8000_00BC);
        chk("lit_j_bubble", {31'd0, if_id_valid}, 32'd0);
        // Stall at 0x1C.
        idle(); chk("lit_pc_14", rom_addr, 32'h0000_0014);
        idle();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0); chk("lit_stall1", rom_addr, 32'h0000_001C);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0); chk("lit_stall2", rom_addr, 32'h0000_001C);
        chk("lit_stall_pc4", if_id_pc4, 32'h0000_001C);
        idle(); chk("lit_stall3", rom_addr, 32'h0000_001C);
        // Branch masks a concurrent exception and stall.
        step(0, 0, 1, 1, 1, 32'h0000_0078, 0, 0, 0);
        chk("lit_br_from", rom_addr, 32'h0000_0020);
        chk("lit_br_flush", {31'd0, id_flush}, 32'd1);
        idle(); chk("lit_br_pc", rom_addr, 32'h0000_0078);
        // Interrupt entry at 0x80 with addu in ID.
        irq_lvl = 1'b1;
        idle();
        idle(); chk("lit_take_pc", rom_addr, 32'h0000_0080);
        chk("lit_take_epc", epc_out, 32'h0000_0080);
        step(0, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0080);
        chk("lit_irq_vec", rom_addr, 32'h8000_0004);
        chk("lit_irq_ack", {31'd0, irq_ack}, 32'd1);
        chk("lit_irq_epc", epc_out, 32'h0000_0080);
        // Return to user mode with irq still high; beq in ID delays re-entry.
        idle(); chk("lit_kernel0", {31'd0, kernel}, 32'd0);
        idle();
        idle(); chk("lit_slip_pc", rom_addr, 32'h0000_0088);
        idle(); chk("lit_slip_ack", {31'd0, irq_ack}, 32'd0);
        chk("lit_slip_epc", epc_out, 32'h0000_008C);
        step(0, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0100);
        chk("lit_reentry", rom_addr, 32'h8000_0004);
        chk("lit_reentry_ack", {31'd0, irq_ack}, 32'd1);
        // Reset while pending.
        idle(); idle();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(); chk("lit_rst_pc", rom_addr, 32'h8000_0000);
        chk("lit_rst_ack", {31'd0, irq_ack}, 32'd0);
        idle(); chk("lit_rst_ack2", {31'd0, irq_ack}, 32'd0);
        irq_lvl = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) irq_lvl = ~irq_lvl;
            s   = ($urandom_range(0, 99) < 15);
            b   = ($urandom_range(0, 99) < 8);
            bt  = {($urandom_range(0, 7) == 0), 21'd0, 8'($urandom), 2'b00};
            e   = m_valid && ($urandom_range(0, 99) < 5);
            j   = m_valid && ($urandom_range(0, 99) < 8);
            jrr = m_valid && ($urandom_range(0, 99) < 6);
            ja  = {1'($urandom), 21'd0, 8'($urandom), 2'b00};
            step(r, irq_lvl, s, e, b, bt, j, jrr, ja);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
